w5500_spi_responder: RTL and testbench



---
 rtl/w5500_spi_responder.sv | 260 ++++++++++++++++++++++++++
 tb/tb_w5500_spi_responder.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/w5500_spi_responder.sv
// W5500-format SPI slave model: 16-bit address, 8-bit control, then data bytes.
// Holds the common register block and, when W5500_RSP_SOCK0_EN is defined,
// the Socket-0 register block. Every completed write byte is reported on wr_*.
`timescale 1ns/1ps
module w5500_spi_responder #(
  parameter int         COMMON_DEPTH = 64,
  parameter int         SOCK_DEPTH   = 48,
  parameter logic [7:0] VERSION_VAL  = 8'h04
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        cs,
  input  logic        sck,
  input  logic        din,
  output logic        dout,
  output logic        wr_strobe,
  output logic [4:0]  wr_bsb,
  output logic [15:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic        frame_done,
  output logic        frame_err
);
  localparam int CA_W = (COMMON_DEPTH > 1) ? $clog2(COMMON_DEPTH) : 1;
  localparam int SA_W = (SOCK_DEPTH > 1) ? $clog2(SOCK_DEPTH) : 1;
`ifdef W5500_RSP_SOCK0_EN
  localparam bit SOCK_EN = 1'b1;
`else
  localparam bit SOCK_EN = 1'b0;
`endif

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_CTRL, S_DATA, S_DRAIN} state_t;
  state_t r_state, w_next;

  logic [1:0]  r_cs_s, r_sck_s, r_din_s;
  logic        r_cs_d, r_sck_d;
  logic [3:0]  r_bit_cnt;
  logic [2:0]  r_byte_cnt;
  logic [14:0] r_shift;
  logic [15:0] r_addr;
  logic [4:0]  r_bsb;
  logic        r_rwb;
  logic [1:0]  r_om;
  logic        r_drain_err;
  logic [7:0]  r_tx;
  logic        r_dout, r_wr_strobe, r_frame_done, r_frame_err;
  logic [4:0]  r_wr_bsb;
  logic [15:0] r_wr_addr;
  logic [7:0]  r_wr_data;
  logic [7:0]  r_common [COMMON_DEPTH];

  logic        w_cs_rise, w_cs_fall, w_sck_rise, w_sck_fall, w_din;
  logic [15:0] w_shift_in;
  logic [7:0]  w_byte, w_rd_byte, w_sock_rd;
  logic [2:0]  w_fixed_n;
  logic        w_fixed_last, w_commit, w_com_ok, w_sock_ok;

  // cs is reset to the "low" value so a frame in flight across reset never
  // produces a falling edge; the responder waits for a genuine high-then-low.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cs_s  <= 2'b00;
      r_sck_s <= 2'b00;
      r_din_s <= 2'b00;
      r_cs_d  <= 1'b0;
      r_sck_d <= 1'b0;
    end else begin
      r_cs_s  <= {r_cs_s[0], cs};
      r_sck_s <= {r_sck_s[0], sck};
      r_din_s <= {r_din_s[0], din};
      r_cs_d  <= r_cs_s[1];
      r_sck_d <= r_sck_s[1];
    end
  end

  assign w_din      = r_din_s[1];
  assign w_cs_rise  = r_cs_s[1] & ~r_cs_d;
  assign w_cs_fall  = ~r_cs_s[1] & r_cs_d;
  assign w_sck_rise = r_sck_s[1] & ~r_sck_d & ~w_cs_rise;
  assign w_sck_fall = ~r_sck_s[1] & r_sck_d;
  assign w_shift_in = {r_shift, w_din};
  assign w_byte     = w_shift_in[7:0];

  // Fixed-length byte count from the operation mode.
  always_comb begin
    w_fixed_n = 3'd0;
    case (r_om)
      2'b01:   w_fixed_n = 3'd1;
      2'b10:   w_fixed_n = 3'd2;
      2'b11:   w_fixed_n = 3'd4;
      default: w_fixed_n = 3'd0;
    endcase
  end
  assign w_fixed_last = (r_om != 2'b00) && (r_byte_cnt == (w_fixed_n - 3'd1));

  // Block decode for the running address.
  assign w_com_ok  = (r_bsb == 5'd0) && (r_addr != 16'h0039) && (int'(r_addr) < COMMON_DEPTH);
  assign w_sock_ok = SOCK_EN && (r_bsb == 5'd1) && (int'(r_addr) < SOCK_DEPTH);
  assign w_commit  = (r_state == S_DATA) && w_sck_rise && (r_bit_cnt == 4'd7) && r_rwb;

  // FSM state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // FSM next state; cs rising aborts from anywhere.
  always_comb begin
    w_next = r_state;
    if (w_cs_rise) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (w_cs_fall) w_next = S_ADDR;
        S_ADDR:  if (w_sck_rise && r_bit_cnt == 4'd15) w_next = S_CTRL;
        S_CTRL:  if (w_sck_rise && r_bit_cnt == 4'd7) w_next = S_DATA;
        S_DATA:  if (w_sck_rise && r_bit_cnt == 4'd7 && w_fixed_last) w_next = S_DRAIN;
        default: w_next = r_state;
      endcase
    end
  end

  // Shifting, counters, MISO and the strobe/frame outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_bit_cnt    <= '0;
      r_byte_cnt   <= '0;
      r_shift      <= '0;
      r_addr       <= '0;
      r_bsb        <= '0;
      r_rwb        <= 1'b0;
      r_om         <= 2'b00;
      r_drain_err  <= 1'b0;
      r_tx         <= '0;
      r_dout       <= 1'b0;
      r_wr_strobe  <= 1'b0;
      r_wr_bsb     <= '0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_frame_done <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_wr_strobe  <= 1'b0;
      r_frame_done <= 1'b0;
      r_frame_err  <= 1'b0;
      if (w_cs_rise) begin
        r_dout <= 1'b0;
        if (r_state != S_IDLE) begin
          r_frame_done <= 1'b1;
          r_frame_err  <= (r_state == S_ADDR) || (r_state == S_CTRL) ||
                          ((r_state == S_DATA) && (r_bit_cnt != 4'd0)) || r_drain_err;
        end
      end else begin
        case (r_state)
          S_IDLE: if (w_cs_fall) begin
            r_bit_cnt   <= '0;
            r_drain_err <= 1'b0;
          end
          S_ADDR: if (w_sck_rise) begin
            r_shift <= w_shift_in[14:0];
            if (r_bit_cnt == 4'd15) begin
              r_addr    <= w_shift_in;
              r_bit_cnt <= '0;
            end else begin
              r_bit_cnt <= r_bit_cnt + 4'd1;
            end
          end
          S_CTRL: if (w_sck_rise) begin
            r_shift <= w_shift_in[14:0];
            if (r_bit_cnt == 4'd7) begin
              r_bsb      <= w_byte[7:3];
              r_rwb      <= w_byte[2];
              r_om       <= w_byte[1:0];
              r_bit_cnt  <= '0;
              r_byte_cnt <= '0;
            end else begin
              r_bit_cnt <= r_bit_cnt + 4'd1;
            end
          end
          S_DATA: begin
            if (w_sck_rise) begin
              r_shift <= w_shift_in[14:0];
              if (r_bit_cnt == 4'd7) begin
                r_bit_cnt  <= '0;
                r_byte_cnt <= r_byte_cnt + 3'd1;
                r_addr     <= r_addr + 16'd1;
                if (r_rwb) begin
                  r_wr_strobe <= 1'b1;
                  r_wr_bsb    <= r_bsb;
                  r_wr_addr   <= r_addr;
                  r_wr_data   <= w_byte;
                end
              end else begin
                r_bit_cnt <= r_bit_cnt + 4'd1;
              end
            end
            if (r_rwb) begin
              r_dout <= 1'b0;
            end else if (w_sck_fall) begin
              if (r_bit_cnt == 4'd0) begin
                r_dout <= w_rd_byte[7];
                r_tx   <= {w_rd_byte[6:0], 1'b0};
              end else begin
                r_dout <= r_tx[7];
                r_tx   <= {r_tx[6:0], 1'b0};
              end
            end
          end
          S_DRAIN: begin
            r_dout <= 1'b0;
            if (w_sck_rise) r_drain_err <= 1'b1;
          end
          default: r_dout <= 1'b0;
        endcase
      end
    end
  end

  // Common register storage; VERSION is not stored, it is a constant on read.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < COMMON_DEPTH; i++) r_common[i] <= 8'h00;
    end else if (w_commit && w_com_ok) begin
      r_common[r_addr[CA_W-1:0]] <= w_byte;
    end
  end

`ifdef W5500_RSP_SOCK0_EN
  logic [7:0] r_sock [SOCK_DEPTH];
  // Socket-0 register storage.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < SOCK_DEPTH; i++) r_sock[i] <= 8'h00;
    end else if (w_commit && w_sock_ok) begin
      r_sock[r_addr[SA_W-1:0]] <= w_byte;
    end
  end
  assign w_sock_rd = r_sock[r_addr[SA_W-1:0]];
`else
  assign w_sock_rd = 8'h00;
`endif

  // Read mux for the byte starting at the running address.
  always_comb begin
    w_rd_byte = 8'h00;
    if (r_bsb == 5'd0) begin
      if (r_addr == 16'h0039)                 w_rd_byte = VERSION_VAL;
      else if (int'(r_addr) < COMMON_DEPTH)   w_rd_byte = r_common[r_addr[CA_W-1:0]];
    end else if (w_sock_ok) begin
      w_rd_byte = w_sock_rd;
    end
  end

  assign dout       = r_dout;
  assign wr_strobe  = r_wr_strobe;
  assign wr_bsb     = r_wr_bsb;
  assign wr_addr    = r_wr_addr;
  assign wr_data    = r_wr_data;
  assign frame_done = r_frame_done;
  assign frame_err  = r_frame_err;
endmodule

// File: tb/tb_w5500_spi_responder.sv
// Scoreboard bench for w5500_spi_responder: directed frames from the bring-up
// list plus random frames, checked against a byte-array register model.
`timescale 1ns/1ps
module tb_w5500_spi_responder;
  logic        clk = 1'b0, rstn = 1'b0, cs = 1'b1, sck = 1'b0, din = 1'b0;
  logic        dout, wr_strobe, frame_done, frame_err;
  logic [4:0]  wr_bsb;
  logic [15:0] wr_addr;
  logic [7:0]  wr_data;

  always #5 clk = ~clk;

  w5500_spi_responder dut (
    .clk(clk), .rstn(rstn), .cs(cs), .sck(sck), .din(din), .dout(dout),
    .wr_strobe(wr_strobe), .wr_bsb(wr_bsb), .wr_addr(wr_addr), .wr_data(wr_data),
    .frame_done(frame_done), .frame_err(frame_err)
  );

`ifdef W5500_RSP_SOCK0_EN
  localparam bit SOCK_EN = 1'b1;
`else
  localparam bit SOCK_EN = 1'b0;
`endif

  typedef struct packed { logic [4:0] bsb; logic [15:0] addr; logic [7:0] data; } strb_t;
  strb_t      exp_wr[$];
  bit         exp_fd[$];
  logic [7:0] exp_rx[$], act_rx[$];
  logic [7:0] m_com[64];
  logic [7:0] m_sock[48];
  logic [7:0] tx_buf[8];
  int errors = 0, checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Register model: plain arrays plus the decode rules.
  function automatic logic [7:0] m_read(input logic [4:0] bsb, input logic [15:0] a);
    if (bsb == 5'd0) begin
      if (a == 16'h0039) return 8'h04;
      if (a < 16'd64)    return m_com[a];
    end else if (bsb == 5'd1 && SOCK_EN && a < 16'd48) begin
      return m_sock[a];
    end
    return 8'h00;
  endfunction

  task automatic m_write(input logic [4:0] bsb, input logic [15:0] a, input logic [7:0] d);
    if (bsb == 5'd0 && a != 16'h0039 && a < 16'd64) m_com[a] = d;
    else if (bsb == 5'd1 && SOCK_EN && a < 16'd48)  m_sock[a] = d;
  endtask

  task automatic m_reset();
    for (int i = 0; i < 64; i++) m_com[i] = 8'h00;
    for (int i = 0; i < 48; i++) m_sock[i] = 8'h00;
  endtask

  // Monitor: consumes expectations whenever the DUT presents an output.
  always @(negedge clk) begin
    strb_t e;
    bit    fe;
    if (rstn && wr_strobe) begin
      if (exp_wr.size() == 0) chk("wr_strobe_unexpected", 32'(wr_strobe), 32'd0);
      else begin
        e = exp_wr.pop_front();
        chk("wr_bsb", 32'(wr_bsb), 32'(e.bsb));
        chk("wr_addr", 32'(wr_addr), 32'(e.addr));
        chk("wr_data", 32'(wr_data), 32'(e.data));
      end
    end
    if (rstn && frame_done) begin
      if (exp_fd.size() == 0) chk("frame_done_unexpected", 32'(frame_done), 32'd0);
      else begin
        fe = exp_fd.pop_front();
        chk("frame_err", 32'(frame_err), 32'(fe));
      end
    end
    while (act_rx.size() > 0 && exp_rx.size() > 0)
      chk("miso_byte", 32'(act_rx.pop_front()), 32'(exp_rx.pop_front()));
  end

  task automatic spi_bit(input logic b, output logic r);
    din = b;
    repeat (6) @(negedge clk);
    r = dout;
    sck = 1'b1;
    repeat (6) @(negedge clk);
    sck = 1'b0;
  endtask

  task automatic spi_byte(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    logic r;
    rx = 8'h00;
    for (int b = 7; b >= 8 - nbits; b--) begin
      spi_bit(tx[b], r);
      rx[b] = r;
    end
  endtask

  // One frame: header, n data bytes from tx_buf, then 'extra' partial bits.
  task automatic run_frame(input bit wr, input logic [4:0] bsb, input logic [1:0] om,
                           input logic [15:0] addr, input int n, input int extra);
    int nfix, eff;
    logic [7:0] rx;
    logic [15:0] a;
    nfix = (om == 2'd1) ? 1 : (om == 2'd2) ? 2 : (om == 2'd3) ? 4 : 0;
    eff  = (om == 2'd0 || n < nfix) ? n : nfix;
    if (wr) begin
      for (int i = 0; i < eff; i++) begin
        a = addr + 16'(i);
        exp_wr.push_back({bsb, a, tx_buf[i]});
        m_write(bsb, a, tx_buf[i]);
      end
    end
    exp_fd.push_back((extra > 0) || (om != 2'd0 && n > nfix));
    cs = 1'b0;
    repeat (6) @(negedge clk);
    spi_byte(addr[15:8], 8, rx); exp_rx.push_back(8'h00); act_rx.push_back(rx);
    spi_byte(addr[7:0], 8, rx);  exp_rx.push_back(8'h00); act_rx.push_back(rx);
    spi_byte({bsb, wr, om}, 8, rx); exp_rx.push_back(8'h00); act_rx.push_back(rx);
    for (int i = 0; i < n; i++) begin
      a = addr + 16'(i);
      spi_byte(tx_buf[i], 8, rx);
      exp_rx.push_back((wr || i >= eff) ? 8'h00 : m_read(bsb, a));
      act_rx.push_back(rx);
    end
    if (extra > 0) spi_byte(8'($urandom), extra, rx);
    repeat (6) @(negedge clk);
    cs = 1'b1;
    repeat (12) @(negedge clk);
    chk("dout_cs_high", 32'(dout), 32'd0);
  endtask

  task automatic check_outputs_zero();
    chk("rst_dout", 32'(dout), 32'd0);
    chk("rst_wr_strobe", 32'(wr_strobe), 32'd0);
    chk("rst_wr_bsb", 32'(wr_bsb), 32'd0);
    chk("rst_wr_addr", 32'(wr_addr), 32'd0);
    chk("rst_wr_data", 32'(wr_data), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_frame_err", 32'(frame_err), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       r;
    logic [7:0] rx;
    int         k;
    logic [4:0] bsb;
    logic [15:0] addr;
    m_reset();
    repeat (4) @(negedge clk);
    check_outputs_zero();
    rstn = 1'b1;
    repeat (8) @(negedge clk);

    // Variable write and readback.
    tx_buf[0] = 8'hC0; tx_buf[1] = 8'hA8; tx_buf[2] = 8'h01; tx_buf[3] = 8'h01;
    run_frame(1'b1, 5'd0, 2'd0, 16'h0001, 4, 0);
    run_frame(1'b0, 5'd0, 2'd0, 16'h0001, 4, 0);
    // Fixed 2-byte socket write and readback.
    tx_buf[0] = 8'h13; tx_buf[1] = 8'h88;
    run_frame(1'b1, 5'd1, 2'd2, 16'h0004, 2, 0);
    run_frame(1'b0, 5'd1, 2'd2, 16'h0004, 2, 0);
    // Fixed 1-byte overrun, then check 001F untouched.
    tx_buf[0] = 8'h02; tx_buf[1] = 8'hFF;
    run_frame(1'b1, 5'd1, 2'd1, 16'h001E, 2, 0);
    run_frame(1'b0, 5'd1, 2'd2, 16'h001E, 2, 0);
    // Version read, write attempt, read again.
    run_frame(1'b0, 5'd0, 2'd1, 16'h0039, 1, 0);
    tx_buf[0] = 8'h55;
    run_frame(1'b1, 5'd0, 2'd1, 16'h0039, 1, 0);
    run_frame(1'b0, 5'd0, 2'd1, 16'h0039, 1, 0);
    // Address wrap FFFF -> 0000.
    tx_buf[0] = 8'hAA; tx_buf[1] = 8'hBB;
    run_frame(1'b1, 5'd0, 2'd0, 16'hFFFF, 2, 0);
    run_frame(1'b0, 5'd0, 2'd0, 16'h0000, 2, 0);
    // Unsupported block.
    tx_buf[0] = 8'h77;
    run_frame(1'b1, 5'd2, 2'd0, 16'h0003, 1, 0);
    run_frame(1'b0, 5'd2, 2'd0, 16'h0003, 1, 0);
    // Partial data byte is not committed.
    tx_buf[0] = 8'h3C;
    run_frame(1'b1, 5'd0, 2'd0, 16'h0010, 1, 3);
    run_frame(1'b0, 5'd0, 2'd0, 16'h0010, 2, 0);

    // Abort after 12 address bits.
    exp_fd.push_back(1'b1);
    cs = 1'b0;
    repeat (6) @(negedge clk);
    for (int i = 0; i < 12; i++) spi_bit(1'($urandom), r);
    repeat (6) @(negedge clk);
    cs = 1'b1;
    repeat (12) @(negedge clk);

    // Reset in the middle of a data byte.
    tx_buf[0] = 8'h9E;
    exp_wr.push_back({5'd0, 16'h0002, 8'h9E});
    cs = 1'b0;
    repeat (6) @(negedge clk);
    spi_byte(8'h00, 8, rx);
    spi_byte(8'h02, 8, rx);
    spi_byte(8'h04, 8, rx);
    spi_byte(8'h9E, 8, rx);
    spi_bit(1'b1, r);
    spi_bit(1'b0, r);
    rstn = 1'b0;
    m_reset();
    repeat (3) @(negedge clk);
    check_outputs_zero();
    rstn = 1'b1;
    for (int i = 0; i < 6; i++) spi_bit(1'b1, r);
    repeat (6) @(negedge clk);
    cs = 1'b1;
    repeat (12) @(negedge clk);
    run_frame(1'b0, 5'd0, 2'd0, 16'h0002, 1, 0);
    run_frame(1'b0, 5'd0, 2'd1, 16'h0039, 1, 0);

    // Random frames.
    for (int f = 0; f < 36; f++) begin
      k = $urandom_range(0, 9);
      bsb = (k < 5) ? 5'd0 : (k < 8) ? 5'd1 : (k == 8) ? 5'd2 : 5'($urandom);
      k = $urandom_range(0, 9);
      addr = (k < 7) ? 16'($urandom_range(0, 70)) : (k == 7) ? 16'h0039 : 16'($urandom);
      for (int i = 0; i < 8; i++) tx_buf[i] = 8'($urandom);
      run_frame(1'($urandom), bsb, 2'($urandom), addr, $urandom_range(1, 5),
                ($urandom_range(0, 5) == 0) ? $urandom_range(1, 7) : 0);
    end

    repeat (20) @(negedge clk);
    chk("pending_strobes", 32'(exp_wr.size()), 32'd0);
    chk("pending_frames", 32'(exp_fd.size()), 32'd0);
    chk("pending_miso", 32'(exp_rx.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
